// File: rtl/fft_stage_sequencer_pkg.sv
// Shared sizes, FSM state codes and the bit-reverse helper for the 32-point FFT sequencer.
package fft_seq_pkg;
    localparam int LOG2N    = 5;
    localparam int N_POINTS = 1 << LOG2N;
    localparam int ADDR_W   = LOG2N;
    localparam int TW_W     = LOG2N - 1;
    localparam int STAGE_W  = 3;
    localparam int BFLY_W   = LOG2N - 1;

    typedef logic [2:0] state_t;
    localparam state_t IDLE  = 3'd0;
    localparam state_t LOAD  = 3'd1;
    localparam state_t ISSUE = 3'd2;
    localparam state_t WAIT  = 3'd3;
    localparam state_t DONE  = 3'd4;

    function automatic logic [ADDR_W-1:0] bitrev5(input logic [ADDR_W-1:0] v);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < ADDR_W; i++) r[i] = v[ADDR_W-1-i];
        return r;
    endfunction
endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Host/butterfly-engine signal bundle of the FFT sequencer; master is the sequencer side.
// The load port group exists only with FFT_SEQ_BITREV_LOAD_EN.
interface fft_stage_sequencer_if;
    import fft_seq_pkg::*;

    logic               start;
    logic               busy;
    logic               done;
    logic               bfly_go;
    logic               bfly_ack;
    logic [ADDR_W-1:0]  addr_a;
    logic [ADDR_W-1:0]  addr_b;
    logic [TW_W-1:0]    tw_idx;
    logic [STAGE_W-1:0] stage;
`ifdef FFT_SEQ_BITREV_LOAD_EN
    logic               in_valid;
    logic               ld_we;
    logic [ADDR_W-1:0]  ld_addr;

    modport master (input start, bfly_ack, in_valid,
                    output busy, done, bfly_go, addr_a, addr_b, tw_idx, stage, ld_we, ld_addr);
    modport slave  (output start, bfly_ack, in_valid,
                    input busy, done, bfly_go, addr_a, addr_b, tw_idx, stage, ld_we, ld_addr);
`else
    modport master (input start, bfly_ack,
                    output busy, done, bfly_go, addr_a, addr_b, tw_idx, stage);
    modport slave  (output start, bfly_ack,
                    input busy, done, bfly_go, addr_a, addr_b, tw_idx, stage);
`endif
endinterface

// File: rtl/fft_stage_sequencer_addr_gen.sv
// Radix-2 DIT in-place addressing: (stage, butterfly) -> leg addresses and twiddle index.
module fft_addr_gen
    import fft_seq_pkg::*;
(
    input  logic [STAGE_W-1:0] stage,
    input  logic [BFLY_W-1:0]  bfly,
    output logic [ADDR_W-1:0]  addr_a,
    output logic [ADDR_W-1:0]  addr_b,
    output logic [TW_W-1:0]    tw_idx
);
    logic [ADDR_W-1:0] b_ext, half, pos, grp;

    always_comb begin
        b_ext  = {1'b0, bfly};
        half   = ADDR_W'(1) << stage;
        pos    = b_ext & (half - ADDR_W'(1));
        grp    = b_ext >> stage;
        // Group index is spread by 2*half; position within the group stays in the low bits.
        addr_a = (grp << (stage + STAGE_W'(1))) | pos;
        addr_b = addr_a + half;
        tw_idx = TW_W'(pos << (STAGE_W'(LOG2N - 1) - stage));
    end
endmodule

// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly scheduler for the 32-point in-place FFT; launches one butterfly at a time.
// Optional bit-reversed input load phase: FFT_SEQ_BITREV_LOAD_EN.
module fft_stage_sequencer
    import fft_seq_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    fft_stage_sequencer_if.master  bus
);
    state_t             state, state_nxt;
    logic [STAGE_W-1:0] stage_cnt, stage_cnt_nxt, stage_q;
    logic [BFLY_W-1:0]  bfly_cnt, bfly_cnt_nxt;
    logic [ADDR_W-1:0]  gen_a, gen_b, addr_a_q, addr_b_q;
    logic [TW_W-1:0]    gen_tw, tw_q;
    logic               go_nxt, busy_nxt, done_nxt;
    logic               go_q, busy_q, done_q;
`ifdef FFT_SEQ_BITREV_LOAD_EN
    logic [ADDR_W-1:0]  load_cnt, load_cnt_nxt;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            stage_cnt <= '0;
            bfly_cnt  <= '0;
`ifdef FFT_SEQ_BITREV_LOAD_EN
            load_cnt  <= '0;
`endif
        end else begin
            state     <= state_nxt;
            stage_cnt <= stage_cnt_nxt;
            bfly_cnt  <= bfly_cnt_nxt;
`ifdef FFT_SEQ_BITREV_LOAD_EN
            load_cnt  <= load_cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt     = state;
        stage_cnt_nxt = stage_cnt;
        bfly_cnt_nxt  = bfly_cnt;
`ifdef FFT_SEQ_BITREV_LOAD_EN
        load_cnt_nxt  = load_cnt;
`endif
        case (state)
            IDLE: if (bus.start) begin
                stage_cnt_nxt = '0;
                bfly_cnt_nxt  = '0;
`ifdef FFT_SEQ_BITREV_LOAD_EN
                load_cnt_nxt  = '0;
                state_nxt     = LOAD;
`else
                state_nxt     = ISSUE;
`endif
            end
`ifdef FFT_SEQ_BITREV_LOAD_EN
            LOAD: if (bus.in_valid) begin
                load_cnt_nxt = load_cnt + ADDR_W'(1);
                if (load_cnt == ADDR_W'(N_POINTS - 1)) state_nxt = ISSUE;
            end
`endif
            ISSUE: state_nxt = WAIT;
            WAIT: if (bus.bfly_ack) begin
                if (bfly_cnt == '1) begin
                    bfly_cnt_nxt = '0;
                    if (stage_cnt == STAGE_W'(LOG2N - 1)) begin
                        stage_cnt_nxt = '0;
                        state_nxt     = DONE;
                    end else begin
                        stage_cnt_nxt = stage_cnt + STAGE_W'(1);
                        state_nxt     = ISSUE;
                    end
                end else begin
                    bfly_cnt_nxt = bfly_cnt + BFLY_W'(1);
                    state_nxt    = ISSUE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Addresses are computed from the next counters so they land together with bfly_go.
    fft_addr_gen u_addr_gen (
        .stage  (stage_cnt_nxt),
        .bfly   (bfly_cnt_nxt),
        .addr_a (gen_a),
        .addr_b (gen_b),
        .tw_idx (gen_tw)
    );

    always_comb begin
        go_nxt   = (state_nxt == ISSUE);
        busy_nxt = (state_nxt == ISSUE) || (state_nxt == WAIT) || (state_nxt == LOAD);
        done_nxt = (state_nxt == DONE);
`ifdef FFT_SEQ_BITREV_LOAD_EN
        bus.ld_we   = (state == LOAD) && bus.in_valid;
        bus.ld_addr = (state == LOAD) ? bitrev5(load_cnt) : '0;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            go_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
            stage_q  <= '0;
        end else begin
            go_q   <= go_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
            if (state_nxt == ISSUE) begin
                addr_a_q <= gen_a;
                addr_b_q <= gen_b;
                tw_q     <= gen_tw;
                stage_q  <= stage_cnt_nxt;
            end
        end
    end

    assign bus.bfly_go = go_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.addr_a  = addr_a_q;
    assign bus.addr_b  = addr_b_q;
    assign bus.tw_idx  = tw_q;
    assign bus.stage   = stage_q;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Randomised-latency bench for fft_stage_sequencer against an arithmetic butterfly-order model.
module tb_fft_stage_sequencer;
    import fft_seq_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fft_stage_sequencer_if bus();
    fft_stage_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int n_chk = 0;
    int n_err = 0;
    int go_cnt = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (bus.bfly_go) go_cnt++;
        if (bus.done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Butterfly b of stage s pairs samples half apart inside groups of 2*half.
    function automatic void ref_bfly(input int s, input int b, output int a, output int bb, output int tw);
        int half, pos, grp;
        half = 2 ** s;
        pos  = b % half;
        grp  = b / half;
        a    = grp * 2 * half + pos;
        bb   = a + half;
        tw   = (pos * ((N_POINTS / 2) / half)) % (N_POINTS / 2);
    endfunction

    function automatic int ref_rev(input int n);
        int r;
        r = 0;
        for (int k = 0; k < LOG2N; k++)
            if ((n >> k) & 1) r = r | (1 << (LOG2N - 1 - k));
        return r;
    endfunction

    // Entered at the negedge of the first LOAD cycle; leaves at the negedge of the first ISSUE cycle.
    task automatic load_phase();
`ifdef FFT_SEQ_BITREV_LOAD_EN
        int n;
        bit v;
        n = 0;
        for (int i = 0; i < 100 && n < N_POINTS; i++) begin
            v = (i % 2 == 0);
            bus.in_valid = v;
            #1;
            chk("ld_we", bus.ld_we, v);
            chk("ld_busy", bus.busy, 1);
            if (v) chk("ld_addr", bus.ld_addr, ref_rev(n));
            @(negedge clk);
            if (v) n++;
        end
        bus.in_valid = 1'b0;
        chk("ld_writes", n, N_POINTS);
`endif
    endtask

    // Entered at the negedge of the first ISSUE cycle; leaves at the negedge of the DONE cycle.
    task automatic run_body(input bit ack_hold, input int max_lat);
        int a, bb, tw, lat;
        for (int s = 0; s < LOG2N; s++) begin
            for (int b = 0; b < N_POINTS / 2; b++) begin
                ref_bfly(s, b, a, bb, tw);
                chk("go", bus.bfly_go, 1);
                chk("busy", bus.busy, 1);
                chk("done_early", bus.done, 0);
                chk("addr_a", bus.addr_a, a);
                chk("addr_b", bus.addr_b, bb);
                chk("tw_idx", bus.tw_idx, tw);
                chk("stage", bus.stage, s);
                lat = ack_hold ? 1 : int'($urandom_range(1, max_lat));
                // An ack in the ISSUE cycle must be ignored.
                bus.bfly_ack = ack_hold ? 1'b1 : 1'($urandom_range(0, 1));
                for (int w = 1; w <= lat; w++) begin
                    @(negedge clk);
                    chk("wait_go", bus.bfly_go, 0);
                    chk("wait_busy", bus.busy, 1);
                    chk("hold_a", bus.addr_a, a);
                    chk("hold_b", bus.addr_b, bb);
                    chk("hold_tw", bus.tw_idx, tw);
                    bus.bfly_ack = ack_hold || (w == lat);
                end
                @(negedge clk);
                if (!ack_hold) bus.bfly_ack = 1'b0;
            end
        end
        chk("done", bus.done, 1);
        chk("done_busy", bus.busy, 0);
        chk("done_go", bus.bfly_go, 0);
        bus.bfly_ack = 1'b0;
    endtask

    task automatic run_fft(input bit hold, input bit ack_hold, input int max_lat);
        int g0;
        g0 = go_cnt;
        chk("idle_busy", bus.busy, 0);
        bus.start = 1'b1;
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        load_phase();
        run_body(ack_hold, max_lat);
        @(negedge clk);
        chk("post_busy", bus.busy, 0);
        chk("post_go", bus.bfly_go, 0);
        chk("post_done", bus.done, 0);
        if (hold) begin
            // start still high in this IDLE cycle: one more FFT begins next cycle.
            @(negedge clk);
            bus.start = 1'b0;
            load_phase();
            run_body(1'b0, max_lat);
            @(negedge clk);
            chk("post2_busy", bus.busy, 0);
        end
        @(negedge clk);
        #1;
        chk("go_count", go_cnt - g0, hold ? 2 * LOG2N * (N_POINTS / 2) : LOG2N * (N_POINTS / 2));
        chk("idle_end_busy", bus.busy, 0);
    endtask

    task automatic abort_test();
        int d0;
        bus.start = 1'b1;
        bus.bfly_ack = 1'b1;
`ifdef FFT_SEQ_BITREV_LOAD_EN
        bus.in_valid = 1'b1;
`endif
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.stage == 3'd2 && bus.busy && !bus.bfly_go) break;
            @(negedge clk);
        end
        chk("abort_stage", bus.stage, 2);
        chk("abort_in_wait", bus.bfly_go, 0);
        bus.bfly_ack = 1'b0;
`ifdef FFT_SEQ_BITREV_LOAD_EN
        bus.in_valid = 1'b0;
`endif
        d0 = done_cnt;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_go", bus.bfly_go, 0);
        chk("rst_addr_a", bus.addr_a, 0);
        chk("rst_addr_b", bus.addr_b, 0);
        chk("rst_tw", bus.tw_idx, 0);
        chk("rst_stage", bus.stage, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_idle", bus.busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.bfly_ack = 1'b0;
`ifdef FFT_SEQ_BITREV_LOAD_EN
        bus.in_valid = 1'b0;
`endif
        #2;
        chk("init_busy", bus.busy, 0);
        chk("init_done", bus.done, 0);
        chk("init_go", bus.bfly_go, 0);
        chk("init_addr_a", bus.addr_a, 0);
        chk("init_addr_b", bus.addr_b, 0);
        chk("init_tw", bus.tw_idx, 0);
        chk("init_stage", bus.stage, 0);
`ifdef FFT_SEQ_BITREV_LOAD_EN
        chk("init_ld_we", bus.ld_we, 0);
        chk("init_ld_addr", bus.ld_addr, 0);
`endif
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        bus.bfly_ack = 1'b1;
        @(negedge clk);
        bus.bfly_ack = 1'b0;
        chk("idle_ack_busy", bus.busy, 0);
        chk("idle_ack_go", bus.bfly_go, 0);

        run_fft(1'b0, 1'b0, 4);
        run_fft(1'b1, 1'b1, 3);
        abort_test();
        run_fft(1'b0, 1'b0, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
